// File: rtl/lut_imm_pkg.sv
// Shared types, default immediate set and the width-extension helper
// for the programmable immediate lookup table.
package lut_imm_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int unsigned NUM_DEFAULTS = 15;
    localparam int unsigned EXT_MAX_W    = 64;

    localparam logic [7:0] DEFAULTS [NUM_DEFAULTS] = '{
        8'd61, 8'd62, 8'd63, 8'd0,   8'd64, 8'd128, 8'd10, 8'd26,
        8'd32, 8'd1,  8'd127, 8'd75, 8'd65, 8'd74,  8'd73
    };

    // Extend the low 'width' bits of value to EXT_MAX_W; caller truncates.
    function automatic logic [EXT_MAX_W-1:0] ext_imm(
        input logic [EXT_MAX_W-1:0] value,
        input int unsigned          width,
        input logic                 sext
    );
        logic [EXT_MAX_W-1:0] upper_mask;
        logic [EXT_MAX_W-1:0] msb_vec;
        logic [EXT_MAX_W-1:0] result;
        upper_mask = {EXT_MAX_W{1'b1}} << width;
        msb_vec    = value >> (width - 1);
        result     = value & ~upper_mask;
        if (sext && msb_vec[0]) begin
            result = result | upper_mask;
        end
        return result;
    endfunction

endpackage

// File: rtl/lut_imm_defaults.sv
// Maps an init pointer to its default immediate; unlisted indices are all-ones.
module lut_imm_defaults
    import lut_imm_pkg::*;
#(
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned DATA_W  = 8
) (
    input  logic [INDEX_W-1:0] ptr,
    output logic [DATA_W-1:0]  value
);

    always_comb begin
        value = '1;
        for (int unsigned i = 0; i < NUM_DEFAULTS; i++) begin
            if (32'(ptr) == i) begin
                value = DATA_W'(DEFAULTS[i]);
            end
        end
    end

endmodule

// File: rtl/lut_imm_prog.sv
// Runtime-programmable immediate table: self-loads defaults after reset,
// then serves combinational reads and accepts loader writes.
module lut_imm_prog
    import lut_imm_pkg::*;
#(
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OUT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] index,
    input  logic               sext,
    output logic [OUT_W-1:0]   immediate,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_accept,
    output logic               ready
);

    localparam int unsigned DEPTH = 2 ** INDEX_W;

    if (OUT_W < DATA_W) begin : g_bad_out_w
        $error("lut_imm_prog: OUT_W must be >= DATA_W");
    end
    if (OUT_W > EXT_MAX_W) begin : g_bad_ext_w
        $error("lut_imm_prog: OUT_W exceeds EXT_MAX_W");
    end

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   ptr_q, ptr_d;
    logic                 ready_q, ready_d;
    logic [DATA_W-1:0]    mem_q [DEPTH];

    logic                 mem_we;
    logic [INDEX_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    dflt_value;

    lut_imm_defaults #(
        .INDEX_W (INDEX_W),
        .DATA_W  (DATA_W)
    ) u_defaults (
        .ptr   (ptr_q),
        .value (dflt_value)
    );

    assign wr_accept = wr_en & ready_q;
    assign ready     = ready_q;

    // Next-state and array write port; reset overrides everything, including a write.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ready_d   = ready_q;
        mem_we    = 1'b0;
        mem_waddr = wr_index;
        mem_wdata = wr_data;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = dflt_value;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end
            end
            READY: begin
                mem_we = wr_accept;
            end
            default: begin
                state_d = INIT;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase

        if (reset) begin
            state_d = INIT;
            ptr_d   = '0;
            ready_d = 1'b0;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        ready_q <= ready_d;
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Gated by ready so uninitialised storage never reaches the datapath.
    always_comb begin
        immediate = '0;
        if (ready_q) begin
            immediate = OUT_W'(ext_imm(EXT_MAX_W'(mem_q[index]), DATA_W, sext));
        end
    end

endmodule

// File: tb/tb_lut_imm_prog.sv
// Bench for lut_imm_prog: directed plan items plus random traffic against a table model.
module tb_lut_imm_prog;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  index;
    logic        sext;
    logic [15:0] immediate;
    logic        wr_en;
    logic [4:0]  wr_index;
    logic [7:0]  wr_data;
    logic        wr_accept;
    logic        ready;

    logic        reset_s;
    logic [2:0]  index_s;
    logic        sext_s;
    logic [7:0]  immediate_s;
    logic        wr_en_s;
    logic [2:0]  wr_index_s;
    logic [3:0]  wr_data_s;
    logic        wr_accept_s;
    logic        ready_s;

    int checks   = 0;
    int failures = 0;

    // Reference model: table contents, ready flag, edges since reset release
    int mdl_mem [32];
    bit mdl_ready;
    int mdl_cnt;

    always #5 clk = ~clk;

    lut_imm_prog #(.INDEX_W(5), .DATA_W(8), .OUT_W(16)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .index     (index),
        .sext      (sext),
        .immediate (immediate),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_data   (wr_data),
        .wr_accept (wr_accept),
        .ready     (ready)
    );

    lut_imm_prog #(.INDEX_W(3), .DATA_W(4), .OUT_W(8)) u_dut_small (
        .clk       (clk),
        .reset     (reset_s),
        .index     (index_s),
        .sext      (sext_s),
        .immediate (immediate_s),
        .wr_en     (wr_en_s),
        .wr_index  (wr_index_s),
        .wr_data   (wr_data_s),
        .wr_accept (wr_accept_s),
        .ready     (ready_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int default_of(input int idx);
        int listed [15] = '{61, 62, 63, 0, 64, 128, 10, 26, 32, 1, 127, 75, 65, 74, 73};
        if (idx < 15) return listed[idx];
        return 255;
    endfunction

    function automatic logic [15:0] mdl_imm();
        int v;
        if (!mdl_ready) return 16'h0000;
        v = mdl_mem[index];
        if (sext && v >= 128) v = v + 65280;
        return 16'(v);
    endfunction

    function automatic void mdl_edge();
        if (reset) begin
            mdl_ready = 1'b0;
            mdl_cnt   = 0;
        end else if (!mdl_ready) begin
            mdl_cnt++;
            if (mdl_cnt == 32) begin
                mdl_ready = 1'b1;
                for (int i = 0; i < 32; i++) mdl_mem[i] = default_of(i);
            end
        end else if (wr_en) begin
            mdl_mem[wr_index] = int'(wr_data);
        end
    endfunction

    // One clock: check outputs mid-cycle, advance the model at the edge, return just after it.
    task automatic cyc(input bit do_exp = 1'b0, input logic [15:0] exp_imm = 16'h0, input string tag = "");
        @(negedge clk);
        check_eq("imm", 32'(immediate), 32'(mdl_imm()));
        check_eq("ready", 32'(ready), 32'(mdl_ready));
        check_eq("wr_accept", 32'(wr_accept), 32'(wr_en & mdl_ready));
        if (do_exp) check_eq(tag, 32'(immediate), 32'(exp_imm));
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic rand_inputs(input int wr_pct);
        index    = 5'($urandom);
        sext     = 1'($urandom);
        wr_en    = ($urandom_range(99) < wr_pct);
        wr_index = 5'($urandom);
        wr_data  = 8'($urandom);
    endtask

    initial begin
        int waited;
        reset = 1'b1; index = '0; sext = 1'b0; wr_en = 1'b0; wr_index = '0; wr_data = '0;
        reset_s = 1'b1; index_s = '0; sext_s = 1'b0; wr_en_s = 1'b0; wr_index_s = '0; wr_data_s = '0;
        mdl_ready = 1'b0; mdl_cnt = 0;
        for (int i = 0; i < 32; i++) mdl_mem[i] = 0;
        @(posedge clk);
        #1;
        repeat (2) cyc();

        // Release both instances; init runs one entry per edge
        reset = 1'b0; reset_s = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            rand_inputs(30);
            if (k == 4) begin
                wr_en = 1'b1; wr_index = 5'd20; wr_data = 8'h11;
            end
            cyc();
            check_eq("ready_edge", 32'(ready), 32'(k >= 32));
            check_eq("ready_small_edge", 32'(ready_s), 32'(k >= 8));
        end

        wr_en = 1'b0;
        index = 5'd0;  sext = 1'b0; index_s = 3'd0; sext_s = 1'b0;
        cyc(1'b1, 16'd61, "idx0");
        check_eq("small_idx0", 32'(immediate_s), 32'h0D);
        index = 5'd5;  index_s = 3'd4;
        cyc(1'b1, 16'd128, "idx5");
        check_eq("small_idx4", 32'(immediate_s), 32'h00);
        index = 5'd14; index_s = 3'd7; sext_s = 1'b1;
        cyc(1'b1, 16'd73, "idx14");
        check_eq("small_idx7_sext", 32'(immediate_s), 32'hFA);
        index = 5'd31;
        cyc(1'b1, 16'd255, "idx31");
        index = 5'd5;  sext = 1'b1;
        cyc(1'b1, 16'hFF80, "idx5_sext");
        sext = 1'b0;
        cyc(1'b1, 16'h0080, "idx5_zext");
        index = 5'd10; sext = 1'b1;
        cyc(1'b1, 16'h007F, "idx10_sext");
        index = 5'd20; sext = 1'b0;
        cyc(1'b1, 16'h00FF, "init_write_dropped");

        // Same-cycle write and read: old value now, new value next cycle
        index = 5'd7; wr_en = 1'b1; wr_index = 5'd7; wr_data = 8'h55;
        cyc(1'b1, 16'd26, "wr_old");
        wr_en = 1'b0;
        cyc(1'b1, 16'h0055, "wr_new");

        for (int n = 0; n < 200; n++) begin
            rand_inputs(30);
            cyc();
        end

        // Reset mid-init restarts the full count
        wr_en = 1'b0; reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (10) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            rand_inputs(20);
            cyc();
            check_eq("reinit_ready_edge", 32'(ready), 32'(k >= 32));
        end

        wr_en = 1'b1; wr_index = 5'd2; wr_data = 8'hAA; index = 5'd2; sext = 1'b0;
        cyc(1'b1, 16'd63, "idx2_before_wr");
        wr_en = 1'b0;
        cyc(1'b1, 16'h00AA, "idx2_written");
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        waited = 0;
        while (ready !== 1'b1 && waited < 40) begin
            cyc();
            waited++;
        end
        check_eq("ready_timeout", 32'(ready), 32'h1);
        index = 5'd2; sext = 1'b0;
        cyc(1'b1, 16'd63, "idx2_restored");

        for (int n = 0; n < 100; n++) begin
            rand_inputs(40);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lut_imm_prog.md
Name: lut_imm_prog

Overview:
- Runtime-programmable, parametrised immediate lookup table for the single-cycle processor datapath. It replaces the fixed 5-bit-index / 8-bit immediate table.
- After reset, an init state machine loads the default immediate set into a register file, one entry per cycle. The processor's program loader can then overwrite entries.
- The read port is combinational, so the single-cycle datapath reads it in the same cycle as decode. The output can be zero- or sign-extended to the datapath width.

Parameters:
- INDEX_W, 5, index width; DEPTH = 2**INDEX_W entries.
- DATA_W, 8, stored immediate width.
- OUT_W, 8, output width; must be >= DATA_W (elaboration-time assertion).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- index  in  INDEX_W  read index from the instruction field.
- sext  in  1  1 = sign-extend the entry to OUT_W, 0 = zero-extend.
- immediate  out  OUT_W  combinational read data.
- wr_en  in  1  write request from the program loader.
- wr_index  in  INDEX_W  write address.
- wr_data  in  DATA_W  write data.
- wr_accept  out  1  combinational; = wr_en & ready; the write commits at this edge.
- ready  out  1  registered; 1 once init is complete.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- States: INIT, READY. Storage is a DEPTH x DATA_W register array plus ptr[INDEX_W].
- Reset (any state, including mid-init): state = INIT, ptr = 0, ready = 0. Array contents are not cleared.
- INIT: on each edge with reset low, array[ptr] = default(ptr) and ptr increments.
  - When ptr == DEPTH-1 is written, the next state is READY and ptr wraps to 0.
  - ready rises exactly DEPTH edges after the first edge with reset low.
- READY: stays in READY until reset. Loader writes are accepted only in this state.
- Default table, value per index (DATA_W = 8):
  - 0:61, 1:62, 2:63, 3:0, 4:64, 5:128, 6:10, 7:26
  - 8:32, 9:1, 10:127, 11:75, 12:65, 13:74, 14:73
  - all other indices: all-ones.
  - For DATA_W > 8 the listed values are zero-extended and the fill entries are all-ones of DATA_W. For DATA_W < 8 the listed values are truncated to the low DATA_W bits.
  - Indices >= 15 that fall outside DEPTH are simply absent.
- Read:
  - immediate = ready ? ext(array[index]) : 0.
  - ext = sign-extension when sext = 1, zero-extension otherwise.
  - Reset value of immediate = 0, since ready = 0.
- Write:
  - wr_en while ready = 0 is ignored: wr_accept = 0 and nothing is queued.
  - An accepted write updates array[wr_index] at the edge.
- Write and read of the same index in the same cycle: immediate shows the old value that cycle and the new value from the next cycle. There is no bypass.
- reset and wr_en high together: reset wins and the write is dropped.
- Loader writes persist until the next reset. Reset re-runs init and restores all defaults.
- No X on any output after reset. Out-of-range conditions cannot occur because index is a full INDEX_W-bit field.

Decomposition:
- Package lut_imm_pkg holds:
  - state enum {INIT, READY}
  - localparam NUM_DEFAULTS = 15
  - the default constant array (8-bit values)
  - function ext_imm(value, sext) for width extension.
- Sub-module lut_imm_defaults: combinational, parametrised by INDEX_W/DATA_W; maps ptr to a default value. It keeps the constant table out of the FSM/array RTL.

Test Plan:
- Reset for 2 cycles, then release → ready = 0 and immediate = 0 for 32 edges; ready = 1 on edge 32. Then index = 0 → 61, index = 5 → 128, index = 14 → 73, index = 31 → 255.
- Extension (OUT_W = 16, ready): index = 5, sext = 1 → 16'hFF80. sext = 0 → 16'h0080. index = 10, sext = 1 → 16'h007F.
- Write while ready: wr_en = 1, wr_index = 7, wr_data = 8'h55, index = 7 in the same cycle → wr_accept = 1; immediate = 26 that cycle, 8'h55 on the next cycle.
- Write during init (ptr = 3): wr_en = 1, wr_index = 20, wr_data = 8'h11 → wr_accept = 0. After ready, index = 20 reads 255.
- Reset mid-init (after 10 edges), released for 32 edges → ready = 1 only after the full 32-edge count from the new release. Then write index 2 = 8'hAA, reset again, wait for ready → index 2 reads 63.
- Parameter sweep INDEX_W = 3, DATA_W = 4 → ready after 8 edges; index 0 reads 4'hD (61 truncated), index 4 reads 4'h0 (64 truncated).
